palette_dac: RTL and testbench
==============================

Name: palette_dac

Overview:
- Final video stage. Consumes the 14-bit priority-resolved colour index from the priority mixer and looks it up in palette RAM.
- Outputs 8-bit-per-channel RGB with blanking delayed to match.
- Palette RAM is on-chip, dual-port: a 68000-style CPU word port with DTACK handshake, and a read-only video port.

Parameters:
- PAL_AW, 12, palette address width; video index uses color_in[PAL_AW-1:0], CPU word address uses cpu_addr[PAL_AW-1:0].
- RGB_FMT, 0, 0 = xxxxRRRRGGGGBBBB (RGB444), 1 = xRRRRRGGGGGBBBBB (RGB555).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- ce_pixel  in  1  pixel enable; at least 3 clk between pulses
- color_in  in  14  colour index from priority mixer
- hblank_in  in  1  horizontal blank, aligned with color_in
- vblank_in  in  1  vertical blank, aligned with color_in
- cs  in  1  CPU chip select (held for whole bus cycle)
- cpu_rw  in  1  1 = read, 0 = write
- cpu_ds_n  in  2  [1] = upper byte strobe, [0] = lower byte strobe, active low
- cpu_addr  in  PAL_AW  CPU word address
- cpu_din  in  16  write data
- cpu_dout  out  16  read data
- cpu_dtack_n  out  1  transfer acknowledge, active low
- red  out  8  red
- green  out  8  green
- blue  out  8  blue
- hblank_out  out  1  delayed hblank
- vblank_out  out  1  delayed vblank

Behaviour:
- Reset: red/green/blue = 0, hblank_out = vblank_out = 1, cpu_dtack_n = 1, cpu_dout = 0, CPU FSM to IDLE, video pipeline valid bits cleared. RAM contents are NOT cleared.
- RAM: 2^PAL_AW x 16, synchronous read with 1 clk latency, byte-write enables.
  - Same-clk CPU write and video read to one address: video port returns old data (read-first).
- CPU FSM (advances every clk, independent of ce_pixel):
  - IDLE: on cs=1, latch addr/rw/ds_n/din. For write, apply byte enables ~cpu_ds_n for one clk. For read, issue read. Go to WAIT.
  - WAIT: one clk for RAM latency. For read, capture cpu_dout = RAM data. Go to ACK.
  - ACK: cpu_dtack_n = 0. Stay while cs=1. On cs=0, cpu_dtack_n = 1 and go to IDLE.
  - Exactly one RAM write per bus cycle, regardless of how long cs is held.
  - ds_n = 2'b11 on a write: no bytes change, handshake still completes.
  - Read with any ds_n returns the full word.
  - cs=1 from reset release: access starts on the first post-reset clk.
  - Reset mid-cycle aborts: dtack_n = 1 immediately, no write is committed after reset.
- Video pipeline, total latency 2 ce_pixel pulses:
  - S1, on ce_pixel: drive RAM video address = color_in[PAL_AW-1:0]; register hblank_in/vblank_in into s1_blank.
  - S2, on the next ce_pixel: from RAM data registered 1 clk after the S1 address, convert to RGB; hblank_out/vblank_out = S1 values.
  - If hblank or vblank is set at S2, RGB = 0.
  - Outputs hold between ce_pixel pulses.
- Conversion:
  - RGB444: R4 = d[11:8], G4 = d[7:4], B4 = d[3:0]; channel = {x4, x4}.
  - RGB555: R5 = d[14:10], G5 = d[9:5], B5 = d[4:0]; channel = {x5, x5[4:2]}. d[15] is ignored.
- color_in bits above PAL_AW are ignored.

Test Plan:
- Reset: assert reset 2 clk -> RGB = 0, hblank_out = vblank_out = 1, cpu_dtack_n = 1; CPU read after reset returns prior RAM content (not zeroed).
- CPU word write addr 0x010 data 0x0F84 (ds_n = 00), RGB_FMT = 0, then present color_in = 0x3010 unblanked -> two ce_pixel pulses later red = 0xFF, green = 0x88, blue = 0x44. dtack_n falls 2 clk after cs and rises the clk after cs drops.
- Byte write: ds_n = 10, din = 0x00AA to addr 0x010 (holding 0x0F84) -> CPU read returns 0x0FAA. Write with ds_n = 11 leaves 0x0FAA and still acknowledges.
- RGB_FMT = 1: word 0x7FFF -> RGB FF/FF/FF; word 0x4210 -> R = 0x84, G = 0x84, B = 0x84.
- Blanking: hblank_in = 1 with a non-zero palette entry -> RGB = 0 and hblank_out = 1, exactly 2 ce_pixel later; vblank_in behaves the same.
- Collision and abort:
  - CPU write to the index being scanned on the same clk as the video read -> that pixel shows old colour, next frame shows new.
  - reset during ACK -> dtack_n = 1 next clk, FSM IDLE.

Source files
------------

// File: rtl/palette_dac.sv
// palette_dac: final video stage. Looks the priority-resolved colour index up in an
// on-chip dual-port palette RAM and expands the entry to 8-bit RGB. The RAM has a
// 68000-style CPU word port with DTACK handshake and a read-only video port.
module palette_dac #(
    parameter int PAL_AW  = 12,
    parameter int RGB_FMT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce_pixel,
    input  logic [13:0]       color_in,
    input  logic              hblank_in,
    input  logic              vblank_in,
    input  logic              cs,
    input  logic              cpu_rw,
    input  logic [1:0]        cpu_ds_n,
    input  logic [PAL_AW-1:0] cpu_addr,
    input  logic [15:0]       cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              cpu_dtack_n,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hblank_out,
    output logic              vblank_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [1:0]        state;
    logic              rd_cycle;
    logic              cpu_start;
    logic [1:0]        ram_we;
    logic [15:0]       cpu_q;
    logic [15:0]       vid_q;
    logic [PAL_AW-1:0] vid_addr;
    logic              vid_rd;
    logic              s1_valid;
    logic              s1_hblank;
    logic              s1_vblank;
    logic [7:0]        conv_r;
    logic [7:0]        conv_g;
    logic [7:0]        conv_b;
    logic              unused_bits;

    logic [15:0] mem [0:(1<<PAL_AW)-1];

    // The bus holds addr/data/strobes stable for the whole cycle, so the single RAM
    // access is issued straight from the bus on the IDLE clock; only the direction
    // needs remembering for the WAIT capture.
    always_comb begin
        cpu_start = (state == ST_IDLE) && cs && !reset;
        ram_we    = (cpu_start && !cpu_rw) ? ~cpu_ds_n : 2'b00;
    end

    // Palette RAM: byte-write CPU port, read-first on both read ports.
    always_ff @(posedge clk) begin
        if (ram_we[1]) mem[cpu_addr][15:8] <= cpu_din[15:8];
        if (ram_we[0]) mem[cpu_addr][7:0]  <= cpu_din[7:0];
        if (cpu_start && cpu_rw) cpu_q <= mem[cpu_addr];
        if (vid_rd) vid_q <= mem[vid_addr];
    end

    // CPU bus handshake: IDLE -> WAIT (RAM latency) -> ACK (hold until cs drops).
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            rd_cycle    <= 1'b0;
            cpu_dtack_n <= 1'b1;
            cpu_dout    <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs) begin
                        rd_cycle <= cpu_rw;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rd_cycle) cpu_dout <= cpu_q;
                    cpu_dtack_n <= 1'b0;
                    state       <= ST_ACK;
                end
                ST_ACK: begin
                    if (!cs) begin
                        cpu_dtack_n <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Palette entry to 8-bit channels; low bits replicate the high bits for full range.
    generate
        if (RGB_FMT == 0) begin : g_rgb444
            assign conv_r = {vid_q[11:8], vid_q[11:8]};
            assign conv_g = {vid_q[7:4], vid_q[7:4]};
            assign conv_b = {vid_q[3:0], vid_q[3:0]};
        end else begin : g_rgb555
            assign conv_r = {vid_q[14:10], vid_q[14:12]};
            assign conv_g = {vid_q[9:5], vid_q[9:7]};
            assign conv_b = {vid_q[4:0], vid_q[4:2]};
        end
    endgenerate

    // Index bits above PAL_AW and unused palette bits are intentionally dropped.
    assign unused_bits = ^{color_in, vid_q};

    // Two-stage video pipe: S1 latches address/blanking, the RAM reads on the very
    // next clk, and S2 on the following ce_pixel converts and presents.
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_rd     <= 1'b0;
            s1_valid   <= 1'b0;
            s1_hblank  <= 1'b1;
            s1_vblank  <= 1'b1;
            red        <= 8'h00;
            green      <= 8'h00;
            blue       <= 8'h00;
            hblank_out <= 1'b1;
            vblank_out <= 1'b1;
        end else begin
            vid_rd <= ce_pixel;
            if (ce_pixel) begin
                vid_addr  <= color_in[PAL_AW-1:0];
                s1_hblank <= hblank_in;
                s1_vblank <= vblank_in;
                s1_valid  <= 1'b1;
                if (s1_valid) begin
                    hblank_out <= s1_hblank;
                    vblank_out <= s1_vblank;
                    if (s1_hblank || s1_vblank) begin
                        red   <= 8'h00;
                        green <= 8'h00;
                        blue  <= 8'h00;
                    end else begin
                        red   <= conv_r;
                        green <= conv_g;
                        blue  <= conv_b;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_palette_dac.sv
// Bench for palette_dac: both colour formats side by side on a shared bus, a
// scoreboard for the video path and direct checks on the CPU handshake.
module tb_palette_dac;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce_pixel = 1'b0;
    logic [13:0] color_in = '0;
    logic        hblank_in = 1'b0;
    logic        vblank_in = 1'b0;
    logic        cs = 1'b0;
    logic        cpu_rw = 1'b1;
    logic [1:0]  cpu_ds_n = 2'b11;
    logic [AW-1:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;

    logic [15:0] dout0, dout1;
    logic        dtack0, dtack1;
    logic [7:0]  red0, green0, blue0, red1, green1, blue1;
    logic        hb0, vb0, hb1, vb1;

    palette_dac #(.PAL_AW(AW), .RGB_FMT(0)) dut0 (
        .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .color_in(color_in),
        .hblank_in(hblank_in), .vblank_in(vblank_in), .cs(cs), .cpu_rw(cpu_rw),
        .cpu_ds_n(cpu_ds_n), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(dout0),
        .cpu_dtack_n(dtack0), .red(red0), .green(green0), .blue(blue0),
        .hblank_out(hb0), .vblank_out(vb0)
    );

    palette_dac #(.PAL_AW(AW), .RGB_FMT(1)) dut1 (
        .clk(clk), .reset(reset), .ce_pixel(ce_pixel), .color_in(color_in),
        .hblank_in(hblank_in), .vblank_in(vblank_in), .cs(cs), .cpu_rw(cpu_rw),
        .cpu_ds_n(cpu_ds_n), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(dout1),
        .cpu_dtack_n(dtack1), .red(red1), .green(green1), .blue(blue1),
        .hblank_out(hb1), .vblank_out(vb1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [23:0] rgb0;
        logic [23:0] rgb1;
        logic        h;
        logic        v;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model[int];
    int          pulse_idx = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] expand(input int x, input int bits);
        if (bits == 4) return 8'(x * 17);
        return 8'((x * 8) + (x / 4));
    endfunction

    function automatic logic [23:0] conv(input int fmt, input logic [15:0] d, input logic blank);
        int v;
        v = int'(d);
        if (blank) return 24'h0;
        if (fmt == 0)
            return {expand((v / 256) % 16, 4), expand((v / 16) % 16, 4), expand(v % 16, 4)};
        return {expand((v / 1024) % 32, 5), expand((v / 32) % 32, 5), expand(v % 32, 5)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete bus cycle; checks DTACK timing and, for reads, the returned word.
    task automatic cpu_access(input logic rw, input logic [AW-1:0] a, input logic [15:0] d,
                              input logic [1:0] ds, input logic [15:0] exp_rd);
        int n;
        logic [15:0] m;
        cs = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_din = d; cpu_ds_n = ds;
        n = 0;
        do begin
            tick();
            n++;
        end while (dtack0 && n < 20);
        check("dtack_latency", 32'(n), 32'd2);
        check("dtack1_low", 32'(dtack1), 32'd0);
        if (!rw) begin
            m = model.exists(int'(a)) ? model[int'(a)] : 16'h0000;
            if (!ds[1]) m[15:8] = d[15:8];
            if (!ds[0]) m[7:0] = d[7:0];
            model[int'(a)] = m;
        end else begin
            check("cpu_dout0", 32'(dout0), 32'(exp_rd));
            check("cpu_dout1", 32'(dout1), 32'(exp_rd));
        end
        cs = 1'b0;
        tick();
        check("dtack_release0", 32'(dtack0), 32'd1);
        check("dtack_release1", 32'(dtack1), 32'd1);
    endtask

    task automatic cpu_read(input logic [AW-1:0] a);
        cpu_access(1'b1, a, 16'h0000, 2'b00, model[int'(a)]);
    endtask

    // Issue one pixel and queue what it must look like when it emerges.
    task automatic push_exp(input logic [13:0] idx, input logic h, input logic v);
        exp_t e;
        logic [15:0] d;
        d = model[int'(idx[AW-1:0])];
        e.rgb0 = conv(0, d, h | v);
        e.rgb1 = conv(1, d, h | v);
        e.h = h;
        e.v = v;
        sb_q.push_back(e);
    endtask

    task automatic pixel(input logic [13:0] idx, input logic h, input logic v);
        color_in = idx; hblank_in = h; vblank_in = v; ce_pixel = 1'b1;
        tick();
        ce_pixel = 1'b0;
        push_exp(idx, h, v);
        tick();
        tick();
    endtask

    // Monitor: each ce_pixel after the first since reset presents the previous pixel.
    always @(posedge clk) begin
        if (reset) begin
            sb_q.delete();
            pulse_idx = 0;
        end else if (ce_pixel) begin
            #2;
            if (pulse_idx > 0) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got empty queue expected entry at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_rgb0", 32'({red0, green0, blue0}), 32'(e.rgb0));
                    check("sb_rgb1", 32'({red1, green1, blue1}), 32'(e.rgb1));
                    check("sb_blank0", 32'({hb0, vb0}), 32'({e.h, e.v}));
                    check("sb_blank1", 32'({hb1, vb1}), 32'({e.h, e.v}));
                end
            end
            pulse_idx++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] addrs[16];
        int n;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_rgb0", 32'({red0, green0, blue0}), 32'h0);
        check("rst_rgb1", 32'({red1, green1, blue1}), 32'h0);
        check("rst_blank", 32'({hb0, vb0, hb1, vb1}), 32'hF);
        check("rst_dtack", 32'({dtack0, dtack1}), 32'h3);
        check("rst_dout", 32'({dout0, dout1}), 32'h0);
        reset = 1'b0;
        tick();

        // Word write and RGB444 lookup
        cpu_access(1'b0, 12'h010, 16'h0F84, 2'b00, 16'h0);
        pixel(14'h3010, 1'b0, 1'b0);
        pixel(14'h3010, 1'b0, 1'b0);
        check("rgb444_const", 32'({red0, green0, blue0}), 32'hFF8844);

        // RGB555 extremes
        cpu_access(1'b0, 12'h020, 16'h7FFF, 2'b00, 16'h0);
        cpu_access(1'b0, 12'h021, 16'h4210, 2'b00, 16'h0);
        pixel(14'h0020, 1'b0, 1'b0);
        pixel(14'h0021, 1'b0, 1'b0);
        check("rgb555_white", 32'({red1, green1, blue1}), 32'hFFFFFF);
        pixel(14'h0010, 1'b0, 1'b0);
        check("rgb555_mid", 32'({red1, green1, blue1}), 32'h848484);

        // Blanking
        pixel(14'h0010, 1'b1, 1'b0);
        pixel(14'h0010, 1'b0, 1'b1);
        check("hblank_rgb", 32'({red0, green0, blue0, hb0}), 32'h1);
        pixel(14'h0010, 1'b0, 1'b0);
        check("vblank_rgb", 32'({red0, green0, blue0, vb0}), 32'h1);

        // Byte writes
        cpu_access(1'b0, 12'h010, 16'h00AA, 2'b10, 16'h0);
        cpu_access(1'b1, 12'h010, 16'h0000, 2'b00, 16'h0FAA);
        cpu_access(1'b0, 12'h010, 16'hFFFF, 2'b11, 16'h0);
        cpu_access(1'b1, 12'h010, 16'h0000, 2'b01, 16'h0FAA);

        // Collision: write lands on the same clk as the video read of that index
        cpu_access(1'b0, 12'h055, 16'h0123, 2'b00, 16'h0);
        color_in = 14'h0055; hblank_in = 1'b0; vblank_in = 1'b0; ce_pixel = 1'b1;
        tick();
        ce_pixel = 1'b0;
        push_exp(14'h0055, 1'b0, 1'b0);
        cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h055; cpu_din = 16'h0ABC; cpu_ds_n = 2'b00;
        n = 0;
        do begin
            tick();
            n++;
        end while (dtack0 && n < 20);
        check("collide_dtack", 32'(n), 32'd2);
        model[32'h055] = 16'h0ABC;
        cs = 1'b0;
        tick();
        pixel(14'h0055, 1'b0, 1'b0);
        check("collide_old", 32'({red0, green0, blue0}), 32'h112233);
        pixel(14'h0055, 1'b0, 1'b0);
        check("collide_new", 32'({red0, green0, blue0}), 32'hAABBCC);

        // Reset with cs already held: RAM keeps content, access starts right after release
        cs = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h010;
        reset = 1'b1;
        tick();
        tick();
        check("rst_cs_dtack", 32'(dtack0), 32'd1);
        reset = 1'b0;
        cpu_access(1'b1, 12'h010, 16'h0000, 2'b00, 16'h0FAA);

        // Reset during ACK aborts the cycle and commits nothing further
        cpu_access(1'b0, 12'h078, 16'h5A5A, 2'b00, 16'h0);
        cs = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h077; cpu_din = 16'h1111; cpu_ds_n = 2'b00;
        n = 0;
        do begin
            tick();
            n++;
        end while (dtack0 && n < 20);
        check("abort_reach_ack", 32'(n), 32'd2);
        model[32'h077] = 16'h1111;
        reset = 1'b1;
        tick();
        check("abort_dtack0", 32'(dtack0), 32'd1);
        check("abort_dtack1", 32'(dtack1), 32'd1);
        cpu_addr = 12'h078; cpu_din = 16'h2222;
        tick();
        cs = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        cpu_read(12'h077);
        cpu_read(12'h078);

        // Randomised traffic over a small palette subset
        for (int i = 0; i < 16; i++) begin
            addrs[i] = AW'(i * 37 + 3);
            cpu_access(1'b0, addrs[i], 16'($urandom), 2'b00, 16'h0);
        end
        for (int i = 0; i < 200; i++) begin
            int sel;
            int k;
            sel = int'($urandom_range(0, 9));
            k = int'($urandom_range(0, 15));
            if (sel < 2) begin
                cpu_access(1'b0, addrs[k], 16'($urandom), 2'($urandom), 16'h0);
            end else if (sel < 4) begin
                cpu_read(addrs[k]);
            end else begin
                pixel({2'($urandom), addrs[k]}, ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 7) == 0));
            end
        end
        pixel({2'b00, addrs[0]}, 1'b0, 1'b0);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
